// File: rtl/pool_pkg.sv
// Shared types and constants for the 2-D pooling block.
package pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } pool_state_t;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  // Elements are signed Q5.3: three fractional bits.
  localparam int FRAC = 3;

  // Maps the requested window size to log2(W); anything other than 2 or 4 behaves as W=1.
  function automatic logic [1:0] windowLog2(input logic [2:0] w);
    case (w)
      3'd2:    windowLog2 = 2'd1;
      3'd4:    windowLog2 = 2'd2;
      default: windowLog2 = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_group_reduce.sv
// Horizontal reduction of one four-lane slice of a beat: two pair results (W=2)
// or a single quad result (W=4), as a sum (average mode) or a signed max.
module pool_group_reduce #(
  parameter int DWIDTH = 8
) (
  input  logic [4*DWIDTH-1:0]      i_data,
  input  logic [3:0]               i_mask,
  input  logic                     i_mode,
  input  logic                     i_quad,
  output logic signed [DWIDTH+3:0] o_red0,
  output logic signed [DWIDTH+3:0] o_red1,
  output logic                     o_mask0,
  output logic                     o_mask1
);
  import pool_pkg::*;

  localparam int AW = DWIDTH + 4;
  // Most-negative element value, sign-extended to the accumulator width.
  localparam logic signed [AW-1:0] MIN_VAL = {{5{1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [AW-1:0] w_lane [4];
  logic signed [AW-1:0] w_pair0;
  logic signed [AW-1:0] w_pair1;

  function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b,
                                                   input logic mode);
    if (mode == POOL_AVG) combine = a + b;
    else                  combine = (a > b) ? a : b;
  endfunction

  // Invalid lanes are replaced by the neutral element of the active reduction.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (i_mask[i]) w_lane[i] = AW'($signed(i_data[i*DWIDTH +: DWIDTH]));
      else           w_lane[i] = (i_mode == POOL_MAX) ? MIN_VAL : '0;
    end
  end

  assign w_pair0 = combine(w_lane[0], w_lane[1], i_mode);
  assign w_pair1 = combine(w_lane[2], w_lane[3], i_mode);
  assign o_red0  = i_quad ? combine(w_pair0, w_pair1, i_mode) : w_pair0;
  assign o_red1  = w_pair1;
  assign o_mask0 = i_quad ? (|i_mask) : (|i_mask[1:0]);
  assign o_mask1 = |i_mask[3:2];

endmodule

// File: rtl/pool_2d.sv
// W x W average/max pooling over a streamed frame of LANES-wide beats, with bypass.
module pool_2d #(
  parameter int DWIDTH = 8,
  parameter int LANES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_enable_pool,
  input  logic                    i_pool_mode,
  input  logic [2:0]              i_pool_window_size,
  input  logic [CNT_W-1:0]        i_num_rows,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [LANES*DWIDTH-1:0] i_inp_data,
  input  logic [LANES-1:0]        i_validity_mask,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [LANES*DWIDTH-1:0] o_out_data,
  output logic [LANES-1:0]        o_out_mask,
  output logic                    o_done_pool
);
  import pool_pkg::*;

  localparam int QUADS  = LANES / 4;
  localparam int GROUPS = LANES / 2;
  localparam int AW     = DWIDTH + 4;
  localparam logic signed [AW:0] SAT_HI = (AW+1)'((1 << (DWIDTH-1)) - 1);
  localparam logic signed [AW:0] SAT_LO = ~SAT_HI;

  pool_state_t r_state, w_stateNext;
  logic                    r_enPool, r_mode;
  logic [1:0]              r_wLog2, r_beatCnt;
  logic [CNT_W-1:0]        r_numRows, r_rowCnt, w_rowNext;
  logic signed [AW-1:0]    r_acc [GROUPS];
  logic [GROUPS-1:0]       r_accMask;
  logic                    r_outValid, r_outIsLast;
  logic [LANES*DWIDTH-1:0] r_outData;
  logic [LANES-1:0]        r_outMask;

  logic                    w_accept, w_outFree, w_pool, w_lastBeat, w_lastRow;
  logic [2:0]              w_winLast;
  logic signed [AW-1:0]    w_red0 [QUADS];
  logic signed [AW-1:0]    w_red1 [QUADS];
  logic [QUADS-1:0]        w_rmask0, w_rmask1;
  logic signed [AW-1:0]    w_beatVal [GROUPS];
  logic [GROUPS-1:0]       w_beatMask;
  logic signed [AW-1:0]    w_accNext [GROUPS];
  logic [GROUPS-1:0]       w_accMaskNext;
  logic [LANES*DWIDTH-1:0] w_poolData;
  logic [LANES-1:0]        w_poolMask;

  function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b,
                                                   input logic mode);
    if (mode == POOL_AVG) combine = a + b;
    else                  combine = (a > b) ? a : b;
  endfunction

  // Average: round-half-up divide by W*W then saturate; max: value is already in range.
  function automatic logic [DWIDTH-1:0] finalize(input logic signed [AW-1:0] a,
                                                 input logic mode,
                                                 input logic [1:0] wl);
    logic signed [AW:0] biased;
    logic signed [AW:0] scaled;
    logic [2:0]         s;
    s      = {wl, 1'b0};
    biased = {a[AW-1], a} + ((AW+1)'(1) << (s - 3'd1));
    scaled = biased >>> s;
    if (mode == POOL_MAX)     finalize = a[DWIDTH-1:0];
    else if (scaled > SAT_HI) finalize = SAT_HI[DWIDTH-1:0];
    else if (scaled < SAT_LO) finalize = SAT_LO[DWIDTH-1:0];
    else                      finalize = scaled[DWIDTH-1:0];
  endfunction

  assign w_outFree   = !r_outValid || i_out_ready;
  assign o_in_ready  = (r_state == S_RUN) && (r_rowCnt != r_numRows) && w_outFree;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_pool      = r_enPool && (r_wLog2 != 2'd0);
  assign w_winLast   = (3'd1 << r_wLog2) - 3'd1;
  assign w_lastBeat  = ({1'b0, r_beatCnt} == w_winLast);
  assign w_rowNext   = r_rowCnt + CNT_W'(1);
  assign w_lastRow   = (w_rowNext == r_numRows);
  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;
  assign o_out_mask  = r_outMask;
  assign o_done_pool = (r_state == S_DONE);

  for (genvar q = 0; q < QUADS; q++) begin : g_quad
    pool_group_reduce #(.DWIDTH(DWIDTH)) u_reduce (
      .i_data  (i_inp_data[q*4*DWIDTH +: 4*DWIDTH]),
      .i_mask  (i_validity_mask[q*4 +: 4]),
      .i_mode  (r_mode),
      .i_quad  (r_wLog2 == 2'd2),
      .o_red0  (w_red0[q]),
      .o_red1  (w_red1[q]),
      .o_mask0 (w_rmask0[q]),
      .o_mask1 (w_rmask1[q])
    );
  end

  // Route the per-quad reductions onto global group indices for the current W.
  always_comb begin
    for (int g = 0; g < GROUPS; g++) w_beatVal[g] = '0;
    w_beatMask = '0;
    for (int q = 0; q < QUADS; q++) begin
      if (r_wLog2 == 2'd2) begin
        w_beatVal[q]  = w_red0[q];
        w_beatMask[q] = w_rmask0[q];
      end else begin
        w_beatVal[2*q]    = w_red0[q];
        w_beatVal[2*q+1]  = w_red1[q];
        w_beatMask[2*q]   = w_rmask0[q];
        w_beatMask[2*q+1] = w_rmask1[q];
      end
    end
  end

  // Fold the current beat into the window; the first beat of a window starts it afresh.
  always_comb begin
    w_accMaskNext = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (r_beatCnt == 2'd0) begin
        w_accNext[g]     = w_beatVal[g];
        w_accMaskNext[g] = w_beatMask[g];
      end else begin
        w_accNext[g]     = combine(r_acc[g], w_beatVal[g], r_mode);
        w_accMaskNext[g] = r_accMask[g] | w_beatMask[g];
      end
    end
  end

  // Pooled output word: FLUSH emits the stored partial window, otherwise the window just closed.
  always_comb begin
    w_poolData = '0;
    w_poolMask = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (g < (LANES >> r_wLog2)) begin
        if (r_state == S_FLUSH) begin
          w_poolData[g*DWIDTH +: DWIDTH] = finalize(r_acc[g], r_mode, r_wLog2);
          w_poolMask[g]                  = r_accMask[g];
        end else begin
          w_poolData[g*DWIDTH +: DWIDTH] = finalize(w_accNext[g], r_mode, r_wLog2);
          w_poolMask[g]                  = w_accMaskNext[g];
        end
      end
    end
  end

  // Frame sequencing: done after the last output leaves, or at once for an empty frame.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_stateNext = (i_num_rows == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (r_outValid && i_out_ready && r_outIsLast)
          w_stateNext = S_DONE;
        else if (w_accept && w_lastRow && w_pool && !w_lastBeat)
          w_stateNext = S_FLUSH;
      end
      S_FLUSH: if (r_outValid && i_out_ready && r_outIsLast) w_stateNext = S_DONE;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  // Configuration latch, window accumulation and the held output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_enPool    <= 1'b0;
      r_mode      <= 1'b0;
      r_wLog2     <= 2'd0;
      r_numRows   <= '0;
      r_rowCnt    <= '0;
      r_beatCnt   <= 2'd0;
      r_accMask   <= '0;
      r_outValid  <= 1'b0;
      r_outIsLast <= 1'b0;
      r_outData   <= '0;
      r_outMask   <= '0;
      for (int g = 0; g < GROUPS; g++) r_acc[g] <= '0;
    end else begin
      if (r_outValid && i_out_ready) r_outValid <= 1'b0;
      if (r_state == S_IDLE && i_start) begin
        r_enPool    <= i_enable_pool;
        r_mode      <= i_pool_mode;
        r_wLog2     <= windowLog2(i_pool_window_size);
        r_numRows   <= i_num_rows;
        r_rowCnt    <= '0;
        r_beatCnt   <= 2'd0;
        r_outIsLast <= 1'b0;
      end
      if (w_accept) begin
        r_rowCnt <= w_rowNext;
        if (!w_pool) begin
          r_outData   <= i_inp_data;
          r_outMask   <= i_validity_mask;
          r_outValid  <= 1'b1;
          r_outIsLast <= w_lastRow;
        end else if (w_lastBeat) begin
          r_outData   <= w_poolData;
          r_outMask   <= w_poolMask;
          r_outValid  <= 1'b1;
          r_outIsLast <= w_lastRow;
          r_beatCnt   <= 2'd0;
        end else begin
          for (int g = 0; g < GROUPS; g++) r_acc[g] <= w_accNext[g];
          r_accMask <= w_accMaskNext;
          r_beatCnt <= r_beatCnt + 2'd1;
        end
      end
      if (r_state == S_FLUSH && !r_outIsLast && w_outFree) begin
        r_outData   <= w_poolData;
        r_outMask   <= w_poolMask;
        r_outValid  <= 1'b1;
        r_outIsLast <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pool_2d.md
POOL_2D -- requirements
Module: pool_2d

Interface
REQ-001 Parameter DWIDTH, default 8, signed Q5.3 element width (FRAC=3 fixed).
REQ-002 Parameter LANES, default 16, elements per beat; SHALL be a multiple of 4.
REQ-003 Parameter CNT_W, default 16, width of row counter.
REQ-004 clk  in  1  rising-edge clock; the block has a single clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; latches configuration and begins a frame.
REQ-007 enable_pool  in  1  0 = bypass, 1 = pool.
REQ-008 pool_mode  in  1  0 = average, 1 = max.
REQ-009 pool_window_size  in  3  window W (legal 1, 2, 4); W×W pooling (W lanes × W beats).
REQ-010 num_rows  in  CNT_W  input beats in the frame.
REQ-011 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-012 inp_data  in  LANES*DWIDTH  lane i at [i*DWIDTH +: DWIDTH].
REQ-013 validity_mask  in  LANES  per-lane valid, sampled with each accepted beat.
REQ-014 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-015 out_data  out  LANES*DWIDTH  result lanes, packed low.
REQ-016 out_mask  out  LANES  per-output-lane valid.
REQ-017 done_pool  out  1  one-cycle pulse at frame completion.

Function
REQ-018 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH after num_rows beats accepted with partial window pending; RUN/FLUSH->DONE when last output is accepted; DONE->IDLE after one cycle.
REQ-019 Config (enable_pool, pool_mode, W, num_rows) latched on start; changes during a frame are ignored; start outside IDLE is ignored.
REQ-020 Illegal W (0, 3, 5-7) is treated as 1.
REQ-021 Beat accepted iff in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-022 out_valid, once high, holds with out_data/out_mask stable until out_ready.
REQ-023 Bypass, or W=1: out_data = accepted inp_data, out_mask = validity_mask, registered, 1-cycle latency.
REQ-024 Pool: group g = lanes g*W..g*W+W-1; the per-group accumulator covers W consecutive beats.
REQ-025 Average: invalid lanes contribute 0; sum width DWIDTH+4; result = (sum + 2^(s-1)) >>> s, where s = 2*log2(W); saturate to signed DWIDTH range.
REQ-026 Max: signed compare; invalid lanes contribute the most-negative value (0x80).
REQ-027 Result is registered one cycle after the W-th beat of a window is accepted; lanes g < LANES/W carry results; higher lanes are 0.
REQ-028 out_mask[g] = OR of validity over the group's W×W inputs; higher bits are 0.
REQ-029 If num_rows is not a multiple of W, FLUSH emits the partial window with the same divisor; missing rows count as 0 (avg) or 0x80 (max).
REQ-030 num_rows=0: start->DONE directly with done_pool pulse and no output.
REQ-031 done_pool pulses the cycle after the final out_valid && out_ready.

Reset
REQ-032 On reset: state IDLE; out_valid, in_ready, done_pool = 0; out_data, out_mask, accumulators, counters = 0.
REQ-033 Reset mid-frame discards partial windows; no output is produced for the aborted frame.

Structure
REQ-034 Package pool_pkg SHALL hold the FSM state enum, mode constants (POOL_AVG, POOL_MAX) and the Q5.3 FRAC constant.
REQ-035 One sub-module, pool_group_reduce, SHALL perform per-group, per-beat horizontal sum/max; it is instantiated LANES/4 times with width handling for W.

Verification
REQ-036 Bypass: lane i = i*8, mask 0xFFFF, num_rows=1 -> out lane i = i*8 one cycle later, out_mask 0xFFFF, done_pool pulse.
REQ-037 W=2 avg: beat0 all 0x08, beat1 all 0x10 -> lanes 0-7 = 0x0C, lanes 8-15 = 0, out_mask 0x00FF.
REQ-038 W=4 max: 4 beats all 0xF8, lane 2 of beat 2 = 0x1C -> out lane0 = 0x1C, lanes 1-3 = 0xF8.
REQ-039 Rounding, W=2 avg, group 0: {0x01,0,0,0} -> 0x00; {0x01,0x01,0,0} -> 0x01; {0x7F,0x7F,0x7F,0x7E} -> 0x7F.
REQ-040 Backpressure: out_ready low 3 cycles -> out_valid held, data stable, in_ready low; resumes without loss.
REQ-041 num_rows=3, W=2: second output is the FLUSH window (row 3 + zero row) -> done_pool; reset after 1 beat of a new frame -> all outputs 0, no output emitted.
